// File: rtl/dmem_arbiter_if.sv
// Bundle of the three requester ports plus the memory port of the data-memory arbiter.
// master = requesters and memory model side, slave = the arbiter.
interface dmem_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic [15:0] cpu_rdata;
   logic        cpu_rvalid;

   logic        dsp_req;
   logic        dsp_lock;
   logic [15:0] dsp_addr;
   logic        dsp_gnt;
   logic [15:0] dsp_rdata;
   logic        dsp_rvalid;

   logic        ms_req;
   logic [1:0]  ms_off;
   logic [15:0] ms_wdata;
   logic        ms_gnt;

   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic        err;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rdata, cpu_rvalid,
      output dsp_req, dsp_lock, dsp_addr,
      input  dsp_gnt, dsp_rdata, dsp_rvalid,
      output ms_req, ms_off, ms_wdata,
      input  ms_gnt,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  err
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rdata, cpu_rvalid,
      input  dsp_req, dsp_lock, dsp_addr,
      output dsp_gnt, dsp_rdata, dsp_rvalid,
      input  ms_req, ms_off, ms_wdata,
      output ms_gnt,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority (ms > cpu > dsp) arbiter for the shared data memory; zero-cycle grant, reads return one cycle later.
// Requesters stall by holding req until gnt; display gets a starvation guard and a bounded atomic lock.
module dmem_arbiter #(
   parameter int DEPTH        = 16387,
   parameter int MMIO_BASE    = 16384,
   parameter int STARVE_LIMIT = 8,
   parameter int LOCK_MAX     = 4
) (
   input logic         clk,
   input logic         rst,
   dmem_arbiter_if.slave bus
);

   typedef enum logic {IDLE, LOCKED} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DSP} owner_t;

   localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
   localparam logic [15:0] MMIO_W    = 16'(MMIO_BASE);
   localparam logic [3:0]  STARVE_TH = 4'(STARVE_LIMIT);
   localparam logic [3:0]  LOCK_TH   = 4'(LOCK_MAX);

   state_t      state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic        relock_blk_q, relock_blk_d;
   owner_t      rd_owner_q, rd_owner_d;
   logic        rd_oor_q, rd_oor_d;
   logic        err_q, err_d;

   logic        lock_hold;
   logic        ms_gnt_c, cpu_gnt_c, dsp_gnt_c, any_gnt;
   logic [15:0] cmd_addr, cmd_wdata;
   logic        cmd_we;
   logic        in_range;
   logic        enter_lock, forced_exit;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         lock_cnt_q   <= 4'd0;
         relock_blk_q <= 1'b0;
         rd_owner_q   <= OWN_NONE;
         rd_oor_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         relock_blk_q <= relock_blk_d;
         rd_owner_q   <= rd_owner_d;
         rd_oor_q     <= rd_oor_d;
         err_q        <= err_d;
      end
   end

   // Grant and memory command; a dropped dsp_lock releases LOCKED in the same cycle.
   always_comb begin
      lock_hold = (state_q == LOCKED) && bus.dsp_lock;
      ms_gnt_c  = 1'b0;
      cpu_gnt_c = 1'b0;
      dsp_gnt_c = 1'b0;
      if (rst) begin
         if (lock_hold)                                 dsp_gnt_c = bus.dsp_req;
         else if (bus.ms_req)                           ms_gnt_c  = 1'b1;
         else if (starve_cnt_q >= STARVE_TH && bus.dsp_req) dsp_gnt_c = 1'b1;
         else if (bus.cpu_req)                          cpu_gnt_c = 1'b1;
         else if (bus.dsp_req)                          dsp_gnt_c = 1'b1;
      end
      any_gnt = ms_gnt_c | cpu_gnt_c | dsp_gnt_c;

      cmd_addr  = 16'd0;
      cmd_wdata = 16'd0;
      cmd_we    = 1'b0;
      if (ms_gnt_c) begin
         cmd_addr  = MMIO_W + {14'd0, bus.ms_off};
         cmd_wdata = bus.ms_wdata;
         cmd_we    = 1'b1;
      end else if (cpu_gnt_c) begin
         cmd_addr  = bus.cpu_addr;
         cmd_wdata = bus.cpu_wdata;
         cmd_we    = bus.cpu_we;
      end else if (dsp_gnt_c) begin
         cmd_addr  = bus.dsp_addr;
      end
      in_range = {1'b0, cmd_addr} < DEPTH_W;
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      forced_exit  = 1'b0;
      enter_lock   = !lock_hold && dsp_gnt_c && bus.dsp_lock && !relock_blk_q;
      if (state_q == LOCKED && !bus.dsp_lock) begin
         state_d    = IDLE;
         lock_cnt_d = 4'd0;
      end
      if ((lock_hold && dsp_gnt_c) || enter_lock) begin
         lock_cnt_d = enter_lock ? 4'd1 : lock_cnt_q + 4'd1;
         state_d    = LOCKED;
         if (lock_cnt_d >= LOCK_TH) begin
            state_d     = IDLE;
            lock_cnt_d  = 4'd0;
            forced_exit = 1'b1;
         end
      end
      // A forced exit blocks relocking until dsp_lock has been low for a cycle.
      relock_blk_d = forced_exit ? 1'b1 : (bus.dsp_lock ? relock_blk_q : 1'b0);

      if (bus.dsp_req && !dsp_gnt_c)
         starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
      else
         starve_cnt_d = 4'd0;

      rd_owner_d = OWN_NONE;
      if (cpu_gnt_c && !bus.cpu_we) rd_owner_d = OWN_CPU;
      else if (dsp_gnt_c)           rd_owner_d = OWN_DSP;
      rd_oor_d = !in_range;
      err_d    = err_q | (any_gnt & !in_range);
   end

   // Outputs
   always_comb begin
      bus.ms_gnt     = ms_gnt_c;
      bus.cpu_gnt    = cpu_gnt_c;
      bus.dsp_gnt    = dsp_gnt_c;
      bus.mem_en     = any_gnt & in_range;
      bus.mem_we     = any_gnt & in_range & cmd_we;
      bus.mem_addr   = cmd_addr;
      bus.mem_wdata  = cmd_wdata;
      bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
      bus.dsp_rvalid = (rd_owner_q == OWN_DSP);
      bus.cpu_rdata  = (rd_owner_q == OWN_CPU && !rd_oor_q) ? bus.mem_rdata : 16'd0;
      bus.dsp_rdata  = (rd_owner_q == OWN_DSP && !rd_oor_q) ? bus.mem_rdata : 16'd0;
      bus.err        = err_q;
   end

endmodule
